// File: rtl/multicycle_control.sv
// Multicycle RISC-V style main control FSM: Moore outputs from state plus the latched opcode class.
// Optional macro MEM_WAIT_EN: FETCH and MEM stall until Mem_Ready_i is high.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] OP_i,
    input  logic       Mem_Ready_i,
    output logic       PC_Write_o,
    output logic       IR_Write_o,
    output logic       I_or_D_o,
    output logic       Mem_Read_o,
    output logic       Mem_Write_o,
    output logic       Reg_Write_o,
    output logic       Branch_o,
    output logic       Jalr_o,
    output logic       AUIPC_o,
    output logic [1:0] Mem_to_Reg_o,
    output logic       ALU_Src_o,
    output logic [2:0] ALU_Op_o,
    output logic [2:0] State_o,
    output logic       Instr_Done_o,
    output logic       Illegal_o
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_NONE, CLS_R, CLS_I, CLS_LUI, CLS_S, CLS_LOAD,
        CLS_B, CLS_JAL, CLS_JALR, CLS_AUIPC
    } opClass_t;

    state_t   state_q, state_d;
    opClass_t class_q, class_d;
    logic     memReady;

`ifdef MEM_WAIT_EN
    assign memReady = Mem_Ready_i;
`else
    logic unusedMemReady;
    assign memReady       = 1'b1;
    assign unusedMemReady = Mem_Ready_i;
`endif

    function automatic opClass_t decodeOp(input logic [6:0] op);
        case (op)
            7'b0110011: decodeOp = CLS_R;
            7'b0010011: decodeOp = CLS_I;
            7'b0110111: decodeOp = CLS_LUI;
            7'b0100011: decodeOp = CLS_S;
            7'b0000011: decodeOp = CLS_LOAD;
            7'b1100011: decodeOp = CLS_B;
            7'b1101111: decodeOp = CLS_JAL;
            7'b1100111: decodeOp = CLS_JALR;
            7'b0010111: decodeOp = CLS_AUIPC;
            default:    decodeOp = CLS_NONE;
        endcase
    endfunction

    function automatic logic [2:0] aluOpOf(input opClass_t cls);
        case (cls)
            CLS_I:     aluOpOf = 3'b001;
            CLS_LUI:   aluOpOf = 3'b010;
            CLS_S:     aluOpOf = 3'b011;
            CLS_AUIPC: aluOpOf = 3'b011;
            CLS_LOAD:  aluOpOf = 3'b100;
            CLS_B:     aluOpOf = 3'b101;
            CLS_JAL:   aluOpOf = 3'b110;
            CLS_JALR:  aluOpOf = 3'b111;
            default:   aluOpOf = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            class_q <= CLS_NONE;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
        end
    end

    logic       pcWrite, irWrite, iOrD, memRead, memWrite, regWrite;
    logic       branch, jalr, auipc, aluSrc, instrDone, illegal;
    logic [1:0] memToReg;
    logic [2:0] aluOp;

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        pcWrite   = 1'b0;
        irWrite   = 1'b0;
        iOrD      = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        regWrite  = 1'b0;
        branch    = 1'b0;
        jalr      = 1'b0;
        auipc     = 1'b0;
        aluSrc    = 1'b0;
        instrDone = 1'b0;
        illegal   = 1'b0;
        memToReg  = 2'b00;
        aluOp     = 3'b000;
        case (state_q)
            FETCH: begin
                memRead = 1'b1;
                if (memReady) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                class_d = decodeOp(OP_i);
                state_d = (class_d == CLS_NONE) ? TRAP : EXEC;
            end
            EXEC: begin
                aluOp  = aluOpOf(class_q);
                aluSrc = (class_q == CLS_I) || (class_q == CLS_LUI) || (class_q == CLS_S) ||
                         (class_q == CLS_LOAD) || (class_q == CLS_JALR) || (class_q == CLS_AUIPC);
                auipc  = (class_q == CLS_AUIPC);
                branch = (class_q == CLS_B);
                case (class_q)
                    CLS_B: begin
                        instrDone = 1'b1;
                        state_d   = FETCH;
                    end
                    CLS_S, CLS_LOAD: state_d = MEM;
                    default:         state_d = WB;
                endcase
            end
            MEM: begin
                iOrD = 1'b1;
                if (class_q == CLS_LOAD) begin
                    memRead = 1'b1;
                    if (memReady) state_d = WB;
                end else if (class_q == CLS_S) begin
                    memWrite = 1'b1;
                    if (memReady) begin
                        instrDone = 1'b1;
                        state_d   = FETCH;
                    end
                end else begin
                    state_d = FETCH;
                end
            end
            WB: begin
                regWrite  = 1'b1;
                instrDone = 1'b1;
                state_d   = FETCH;
                if (class_q == CLS_LOAD) begin
                    memToReg = 2'b01;
                end else if ((class_q == CLS_JAL) || (class_q == CLS_JALR)) begin
                    memToReg = 2'b10;
                    pcWrite  = 1'b1;
                    jalr     = (class_q == CLS_JALR);
                end
            end
            TRAP: illegal = 1'b1;
            default: state_d = FETCH;
        endcase
    end

    // Reset masks the outputs combinationally so nothing leaks while it is held.
    always_comb begin
        PC_Write_o   = pcWrite   & ~reset;
        IR_Write_o   = irWrite   & ~reset;
        I_or_D_o     = iOrD      & ~reset;
        Mem_Read_o   = memRead   & ~reset;
        Mem_Write_o  = memWrite  & ~reset;
        Reg_Write_o  = regWrite  & ~reset;
        Branch_o     = branch    & ~reset;
        Jalr_o       = jalr      & ~reset;
        AUIPC_o      = auipc     & ~reset;
        ALU_Src_o    = aluSrc    & ~reset;
        Instr_Done_o = instrDone & ~reset;
        Illegal_o    = illegal   & ~reset;
        Mem_to_Reg_o = reset ? 2'b00 : memToReg;
        ALU_Op_o     = reset ? 3'b000 : aluOp;
        State_o      = reset ? 3'b000 : state_q;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues per-cycle expected outputs, a negedge monitor pops and compares.
// Define MEM_WAIT_EN to also exercise the memory wait-state scenarios.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] OP_i;
    logic       Mem_Ready_i;
    logic       PC_Write_o, IR_Write_o, I_or_D_o, Mem_Read_o, Mem_Write_o, Reg_Write_o;
    logic       Branch_o, Jalr_o, AUIPC_o, ALU_Src_o, Instr_Done_o, Illegal_o;
    logic [1:0] Mem_to_Reg_o;
    logic [2:0] ALU_Op_o, State_o;

    typedef struct packed {
        logic       pcW;
        logic       irW;
        logic       iOrD;
        logic       memRd;
        logic       memWr;
        logic       regWr;
        logic       branch;
        logic       jalr;
        logic       auipc;
        logic [1:0] m2r;
        logic       aluSrc;
        logic [2:0] aluOp;
        logic [2:0] state;
        logic       done;
        logic       illegal;
    } outVec_t;

    typedef struct {
        string   name;
        outVec_t v;
    } expEntry_t;

    expEntry_t expQ[$];
    outVec_t   actual;
    int        checks   = 0;
    int        failures = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .OP_i(OP_i), .Mem_Ready_i(Mem_Ready_i),
        .PC_Write_o(PC_Write_o), .IR_Write_o(IR_Write_o), .I_or_D_o(I_or_D_o),
        .Mem_Read_o(Mem_Read_o), .Mem_Write_o(Mem_Write_o), .Reg_Write_o(Reg_Write_o),
        .Branch_o(Branch_o), .Jalr_o(Jalr_o), .AUIPC_o(AUIPC_o),
        .Mem_to_Reg_o(Mem_to_Reg_o), .ALU_Src_o(ALU_Src_o), .ALU_Op_o(ALU_Op_o),
        .State_o(State_o), .Instr_Done_o(Instr_Done_o), .Illegal_o(Illegal_o)
    );

    assign actual = {PC_Write_o, IR_Write_o, I_or_D_o, Mem_Read_o, Mem_Write_o, Reg_Write_o,
                     Branch_o, Jalr_o, AUIPC_o, Mem_to_Reg_o, ALU_Src_o, ALU_Op_o,
                     State_o, Instr_Done_o, Illegal_o};

    function automatic outVec_t zeroV();
        zeroV = '0;
    endfunction

    function automatic outVec_t fetchV(input logic ready);
        fetchV       = '0;
        fetchV.memRd = 1'b1;
        fetchV.pcW   = ready;
        fetchV.irW   = ready;
    endfunction

    function automatic outVec_t decodeV();
        decodeV       = '0;
        decodeV.state = 3'd1;
    endfunction

    function automatic outVec_t execV(input logic [2:0] aop, input logic asrc,
                                      input logic br, input logic aui, input logic done);
        execV        = '0;
        execV.state  = 3'd2;
        execV.aluOp  = aop;
        execV.aluSrc = asrc;
        execV.branch = br;
        execV.auipc  = aui;
        execV.done   = done;
    endfunction

    function automatic outVec_t memV(input logic rd, input logic wr, input logic done);
        memV       = '0;
        memV.state = 3'd3;
        memV.iOrD  = 1'b1;
        memV.memRd = rd;
        memV.memWr = wr;
        memV.done  = done;
    endfunction

    function automatic outVec_t wbV(input logic [1:0] m2r, input logic pcw, input logic jr);
        wbV       = '0;
        wbV.state = 3'd4;
        wbV.regWr = 1'b1;
        wbV.done  = 1'b1;
        wbV.m2r   = m2r;
        wbV.pcW   = pcw;
        wbV.jalr  = jr;
    endfunction

    function automatic outVec_t trapV();
        trapV         = '0;
        trapV.state   = 3'd5;
        trapV.illegal = 1'b1;
    endfunction

    task automatic pushExp(input string name, input outVec_t v);
        expQ.push_back('{name, v});
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] op, input int n);
        OP_i = op;
        waitCycles(n);
    endtask

    task automatic checkOutput(input expEntry_t e);
        checks++;
        if (actual !== e.v) begin
            failures++;
            $display("[TB] FAIL %s: got=%05h expected=%05h (state got=%0d exp=%0d)",
                     e.name, actual, e.v, actual.state, e.v.state);
        end
    endtask

    // Monitor: one expected vector per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (expQ.size() != 0) checkOutput(expQ.pop_front());
    end

    // Four-cycle instruction through EXEC and WB.
    task automatic runWbInstr(input string nm, input logic [6:0] op, input logic [2:0] aop,
                              input logic asrc, input logic aui, input logic [1:0] m2r,
                              input logic pcw, input logic jr);
        pushExp({nm, "_fetch"}, fetchV(1'b1));
        pushExp({nm, "_decode"}, decodeV());
        pushExp({nm, "_exec"}, execV(aop, asrc, 1'b0, aui, 1'b0));
        pushExp({nm, "_wb"}, wbV(m2r, pcw, jr));
        applyStimulus(op, 4);
    endtask

    initial begin
        reset       = 1'b1;
        OP_i        = 7'b0;
        Mem_Ready_i = 1'b1;
        @(posedge clk);
        #1;
        pushExp("reset_hold0", zeroV());
        pushExp("reset_hold1", zeroV());
        waitCycles(2);
        reset = 1'b0;

        runWbInstr("R",     7'b0110011, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        pushExp("LOAD_fetch", fetchV(1'b1));
        pushExp("LOAD_decode", decodeV());
        pushExp("LOAD_exec", execV(3'b100, 1'b1, 1'b0, 1'b0, 1'b0));
        pushExp("LOAD_mem", memV(1'b1, 1'b0, 1'b0));
        pushExp("LOAD_wb", wbV(2'b01, 1'b0, 1'b0));
        applyStimulus(7'b0000011, 5);

        runWbInstr("JALR",  7'b1100111, 3'b111, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
        runWbInstr("JAL",   7'b1101111, 3'b110, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
        runWbInstr("I",     7'b0010011, 3'b001, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        runWbInstr("LUI",   7'b0110111, 3'b010, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        runWbInstr("AUIPC", 7'b0010111, 3'b011, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);

        pushExp("S_fetch", fetchV(1'b1));
        pushExp("S_decode", decodeV());
        pushExp("S_exec", execV(3'b011, 1'b1, 1'b0, 1'b0, 1'b0));
        pushExp("S_mem", memV(1'b0, 1'b1, 1'b1));
        applyStimulus(7'b0100011, 4);

        pushExp("B_fetch", fetchV(1'b1));
        pushExp("B_decode", decodeV());
        pushExp("B_exec", execV(3'b101, 1'b0, 1'b1, 1'b0, 1'b1));
        applyStimulus(7'b1100011, 3);

        pushExp("ILL_fetch", fetchV(1'b1));
        pushExp("ILL_decode", decodeV());
        for (int i = 0; i < 12; i++) pushExp("ILL_trap", trapV());
        applyStimulus(7'b1111111, 14);
        reset = 1'b1;
        pushExp("trap_reset", zeroV());
        waitCycles(1);
        reset = 1'b0;
        runWbInstr("R_after_trap", 7'b0110011, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        pushExp("Rabort_fetch", fetchV(1'b1));
        pushExp("Rabort_decode", decodeV());
        applyStimulus(7'b0110011, 2);
        reset = 1'b1;
        pushExp("Rabort_reset0", zeroV());
        pushExp("Rabort_reset1", zeroV());
        waitCycles(2);
        reset = 1'b0;
        runWbInstr("R_after_abort", 7'b0110011, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

`ifdef MEM_WAIT_EN
        pushExp("Swait_fetch_stall0", fetchV(1'b0));
        pushExp("Swait_fetch_stall1", fetchV(1'b0));
        pushExp("Swait_fetch", fetchV(1'b1));
        pushExp("Swait_decode", decodeV());
        pushExp("Swait_exec", execV(3'b011, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) pushExp("Swait_mem_stall", memV(1'b0, 1'b1, 1'b0));
        pushExp("Swait_mem_done", memV(1'b0, 1'b1, 1'b1));
        OP_i        = 7'b0100011;
        Mem_Ready_i = 1'b0;
        waitCycles(2);
        Mem_Ready_i = 1'b1;
        waitCycles(3);
        Mem_Ready_i = 1'b0;
        waitCycles(3);
        Mem_Ready_i = 1'b1;
        waitCycles(1);
        pushExp("Swait_next_fetch", fetchV(1'b1));
        waitCycles(1);
`endif

        for (int i = 0; i < 5 && expQ.size() != 0; i++) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: pending=%0d required=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
